pic_sync_ctrl: RTL

Synchronous, parametrised successor to the team's 8259-style programmable interrupt controller. It collects N_IRQ request lines and resolves them with fully-nested fixed or rotating priority. It drives a single registered INT to the CPU and returns a vector on a single-cycle acknowledge. Compared with the existing PIC it adds:
- per-line edge/level trigger selection
- auto-EOI mode
- a bus-readable IRR/ISR
- a configurable line count

---
 rtl/pic_sync_pkg.sv | 29 ++
 rtl/pic_prio_resolver.sv | 31 +++
 rtl/pic_sync_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pic_sync_pkg.sv
// Shared constants and types for the synchronous programmable interrupt controller.
package pic_sync_pkg;

    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_IMR   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TRIG  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_VBASE = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_EOI   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_IRR   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_ISR   = 3'd5;

    localparam int unsigned CTRL_W    = 2;
    localparam int unsigned CTRL_ROT  = 0;
    localparam int unsigned CTRL_AEOI = 1;

    // Control register payload; rot sits in bit 0, aeoi in bit 1
    typedef struct packed {
        logic aeoi;
        logic rot;
    } ctrl_t;

    // The specific-EOI flag is always the MSB of the register bus
    function automatic int unsigned eoi_specific_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: finds the first set request starting at ptr, wrapping modulo N.
module pic_prio_resolver #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    logic [IW:0] pos;

    // Walk from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        pos     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                found_c = 1'b1;
                idx_c   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pic_sync_ctrl.sv
// Synchronous N-line programmable interrupt controller with fixed/rotating nested
// priority, per-line edge/level triggering, auto-EOI and a readable IRR/ISR.
module pic_sync_ctrl
    import pic_sync_pkg::*;
#(
    parameter int unsigned N_IRQ  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned VEC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              int_o,
    input  logic              inta,
    output logic [VEC_W-1:0]  vec,
    output logic              vec_valid
);

    localparam int unsigned IDX_W        = $clog2(N_IRQ);
    localparam int unsigned EOI_SPEC_BIT = eoi_specific_bit(DATA_W);

    logic [N_IRQ-1:0] imr_q;
    logic [N_IRQ-1:0] trig_q;
    logic [N_IRQ-1:0] irr_q;
    logic [N_IRQ-1:0] isr_q;
    logic [N_IRQ-1:0] prev_irq_q;
    ctrl_t            ctrl_q;
    logic [VEC_W-1:0] vbase_q;
    logic [IDX_W-1:0] ptr_q;

    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] ptr_eff;
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic             isr_found;
    logic [IDX_W-1:0] isr_idx;

    logic             eoi_hit;
    logic [IDX_W-1:0] eoi_idx;
    logic [N_IRQ-1:0] eoi_clr;
    logic             ack_hit;
    logic [N_IRQ-1:0] ack_clr;

    logic [N_IRQ-1:0]  irr_n;
    logic [N_IRQ-1:0]  isr_n;
    logic [IDX_W-1:0]  ptr_n;
    logic              int_n;
    logic [VEC_W-1:0]  vec_n;
    logic [DATA_W-1:0] rdata_n;

    // Distance of line i below the top-priority position p
    function automatic logic [IDX_W-1:0] rank_of(input logic [IDX_W-1:0] i,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W:0] r;
        r = {1'b0, i} + (IDX_W+1)'(N_IRQ) - {1'b0, p};
        if (r >= (IDX_W+1)'(N_IRQ)) begin
            r = r - (IDX_W+1)'(N_IRQ);
        end
        return r[IDX_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_IRQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign wr_en   = cs & wr;
    assign rd_en   = cs & rd;
    assign ptr_eff = ctrl_q.rot ? ptr_q : '0;

    pic_prio_resolver #(.N(N_IRQ), .IW(IDX_W)) u_cand_res (
        .req     (irr_q & ~imr_q),
        .ptr     (ptr_eff),
        .found_c (cand_found),
        .idx_c   (cand_idx)
    );

    pic_prio_resolver #(.N(N_IRQ), .IW(IDX_W)) u_isr_res (
        .req     (isr_q),
        .ptr     (ptr_eff),
        .found_c (isr_found),
        .idx_c   (isr_idx)
    );

    // EOI target: explicit line for a specific EOI, otherwise the top in-service line
    always_comb begin
        eoi_hit = 1'b0;
        eoi_idx = '0;
        if (wr_en && (addr == ADDR_EOI)) begin
            if (wdata[EOI_SPEC_BIT]) begin
                if ((32'(wdata[IDX_W-1:0]) < N_IRQ) && isr_q[wdata[IDX_W-1:0]]) begin
                    eoi_hit = 1'b1;
                    eoi_idx = wdata[IDX_W-1:0];
                end
            end else if (isr_found) begin
                eoi_hit = 1'b1;
                eoi_idx = isr_idx;
            end
        end
    end

    assign eoi_clr = eoi_hit ? (N_IRQ'(1) << eoi_idx) : '0;
    assign ack_hit = inta & cand_found;
    assign ack_clr = ack_hit ? (N_IRQ'(1) << cand_idx) : '0;

    // Next request/service state; a fresh edge outranks the ack clear on the same line
    always_comb begin
        irr_n = (trig_q & irq) |
                (~trig_q & ((irq & ~prev_irq_q) | (irr_q & ~ack_clr)));
        isr_n = isr_q & ~eoi_clr;
        if (ack_hit && !ctrl_q.aeoi) begin
            isr_n = isr_n | ack_clr;
        end

        ptr_n = ptr_q;
        if (!ctrl_q.rot) begin
            ptr_n = '0;
        end else if (ack_hit && ctrl_q.aeoi) begin
            ptr_n = inc_wrap(cand_idx);
        end else if (eoi_hit) begin
            ptr_n = inc_wrap(eoi_idx);
        end

        int_n = cand_found &&
                (!isr_found || (rank_of(cand_idx, ptr_eff) < rank_of(isr_idx, ptr_eff)));

        vec_n = vbase_q + (ack_hit ? VEC_W'(cand_idx) : VEC_W'(N_IRQ - 1));
    end

    always_comb begin
        rdata_n = '0;
        case (addr)
            ADDR_IMR:   rdata_n = DATA_W'(imr_q);
            ADDR_TRIG:  rdata_n = DATA_W'(trig_q);
            ADDR_CTRL:  rdata_n = DATA_W'(ctrl_q);
            ADDR_VBASE: rdata_n = DATA_W'(vbase_q);
            ADDR_IRR:   rdata_n = DATA_W'(irr_q);
            ADDR_ISR:   rdata_n = DATA_W'(isr_q);
            default:    rdata_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imr_q      <= '1;
            trig_q     <= '0;
            ctrl_q     <= '0;
            vbase_q    <= '0;
            irr_q      <= '0;
            isr_q      <= '0;
            ptr_q      <= '0;
            prev_irq_q <= '0;
            rdata      <= '0;
            int_o      <= 1'b0;
            vec        <= '0;
            vec_valid  <= 1'b0;
        end else begin
            prev_irq_q <= irq;
            irr_q      <= irr_n;
            isr_q      <= isr_n;
            ptr_q      <= ptr_n;
            int_o      <= int_n;
            vec_valid  <= inta;
            if (inta) begin
                vec <= vec_n;
            end
            if (rd_en) begin
                rdata <= rdata_n;
            end
            if (wr_en) begin
                case (addr)
                    ADDR_IMR:   imr_q   <= wdata[N_IRQ-1:0];
                    ADDR_TRIG:  trig_q  <= wdata[N_IRQ-1:0];
                    ADDR_CTRL: begin
                        ctrl_q.rot  <= wdata[CTRL_ROT];
                        ctrl_q.aeoi <= wdata[CTRL_AEOI];
                    end
                    ADDR_VBASE: vbase_q <= wdata[VEC_W-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
